shutdown_sense_scanner: RTL

- Time-multiplexes one shared shutdown-sense comparator line across up to 8 gradient boards.
- Drives the external analog mux select and waits a settle time after each change.
- Debounces the sampled sense level and latches the first board found in shutdown.
- Outputs feed the system hardware manager as its shutdown_sense / sense_num inputs.

---
 rtl/shutdown_sense_scanner.sv | 112 +++++++++++
 1 files changed

// File: rtl/shutdown_sense_scanner.sv
// Scans one shared shutdown-sense comparator across up to 8 boards via an external mux, latching the first fault.
// Dwell per clean board is SETTLE_CYCLES+1 clocks; a fault latches SETTLE_CYCLES+DEBOUNCE clocks after mux_sel changes; no backpressure.
module shutdown_sense_scanner #(
  parameter int unsigned SETTLE_CYCLES = 250,
  parameter int unsigned DEBOUNCE      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] board_mask,
  input  logic       sense_in,
  input  logic       clear,
  output logic [2:0] mux_sel,
  output logic       scan_active,
  output logic       shutdown_sense,
  output logic [2:0] sense_num
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, LATCHED} state_t;

  localparam logic [15:0] SETTLE_LAST   = 16'(SETTLE_CYCLES - 1);
  localparam logic [4:0]  DEBOUNCE_LAST = 5'(DEBOUNCE - 1);

  state_t      state;
  logic        sense_m;
  logic        sense_s;
  logic [15:0] settle_cnt;
  logic [4:0]  sample_cnt;

  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) lowest_set = 3'(i);
    end
  endfunction

  // Smallest forward offset wins; falls back to cur when it is the only enabled board.
  function automatic logic [2:0] next_set(input logic [2:0] cur, input logic [7:0] mask);
    logic [2:0] idx;
    next_set = cur;
    for (int i = 7; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (mask[idx]) next_set = idx;
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sense_m <= 1'b0;
      sense_s <= 1'b0;
    end else begin
      sense_m <= sense_in;
      sense_s <= sense_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state          <= IDLE;
      mux_sel        <= 3'd0;
      shutdown_sense <= 1'b0;
      sense_num      <= 3'd0;
      settle_cnt     <= 16'd0;
      sample_cnt     <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|board_mask) begin
            mux_sel    <= lowest_set(board_mask);
            settle_cnt <= 16'd0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 16'd1;
          if (settle_cnt == SETTLE_LAST) begin
            sample_cnt <= 5'd0;
            state      <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (!sense_s) begin
            if (board_mask == 8'd0) begin
              state <= IDLE;
            end else begin
              mux_sel    <= next_set(mux_sel, board_mask);
              settle_cnt <= 16'd0;
              state      <= SETTLE;
            end
          end else if (sample_cnt == DEBOUNCE_LAST) begin
            shutdown_sense <= 1'b1;
            sense_num      <= mux_sel;
            state          <= LATCHED;
          end else begin
            sample_cnt <= sample_cnt + 5'd1;
          end
        end
        LATCHED: begin
          if (clear) begin
            shutdown_sense <= 1'b0;
            sense_num      <= 3'd0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign scan_active = (state == SETTLE) || (state == SAMPLE);

endmodule
